cvxif_offload_initiator: RTL and testbench
==========================================

# cvxif_offload_initiator

Core-side initiator of the CV-X-IF interface, driving the request channels a coprocessor responds to. Takes one offloaded instruction at a time from the core issue stage, performs the combined issue/register handshake, and sends the commit. Tracks up to MaxOutstanding accepted instructions by id and forwards out-of-order results to core writeback.

## Interface
- NrRgprPorts, 2: source operands per instruction
- XLEN, 32: operand/result width
- IdWidth, 3: width of id_t; must equal $bits(id_t)
- MaxOutstanding, 4: accepted-but-unretired limit, ≤ 2**IdWidth
- TimeoutCycles, 1024: watchdog threshold (macro only)
- hartid_t, id_t, x_issue_req_t, x_issue_resp_t, x_register_t, x_commit_t, x_result_t, cvxif_req_t, cvxif_resp_t: CV-X-IF types, as the coprocessor uses them

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- offload_valid_i / offload_ready_o  in/out  1  core offload handshake
- offload_instr_i  in  32  instruction
- offload_rs_i  in  NrRgprPorts×XLEN  operands
- offload_hartid_i  in  hartid_t  hart
- offload_kill_i  in  1  commit_kill to send for this instruction
- accept_o / reject_o  out  1  one-cycle pulse per issue outcome
- offload_id_o  out  IdWidth  id used; valid with accept_o/reject_o
- cvxif_req_o  out  cvxif_req_t  issue/register/commit/result_ready to coprocessor
- cvxif_resp_i  in  cvxif_resp_t  issue_ready/issue_resp/result from coprocessor
- wb_valid_o / wb_ready_i  out/in  1  writeback handshake
- wb_data_o  out  XLEN; wb_rd_o  out  5; wb_we_o  out  1; wb_id_o  out  IdWidth
- busy_o  out  1  any id outstanding
- protocol_err_o  out  1  sticky: result for non-outstanding id
- timeout_o  out  1  sticky watchdog flag

## Operation
- FSM IDLE, ISSUE, COMMIT.
- IDLE: offload_ready_o = (count < MaxOutstanding) & !busy[next_id]. On handshake latch instr, rs, hartid, kill; id = next_id; -> ISSUE.
- ISSUE: issue_valid = register_valid = 1; register.rs = latched operands, rs_valid all ones; hartid/id identical on both channels. Hold stable until issue_ready (register_ready equals issue_ready in non-split mode).
  - issue_resp.accept = 1: accept_o pulse; set busy[id]; count++; next_id++ (wraps mod 2**IdWidth); -> COMMIT.
  - accept = 0: reject_o pulse; no state change; -> IDLE.
- COMMIT: commit_valid = 1 for exactly one cycle with latched hartid, id, commit_kill; if kill, clear busy[id] and count-- that cycle (no result expected); -> IDLE.
- Results: result_ready = wb_ready_i. wb_valid_o = result_valid & busy[result.id]; wb_* = result fields. On handshake clear busy[result.id], count--.
- Result with busy[id] = 0: consumed regardless of wb_ready_i, wb_valid_o stays 0, protocol_err_o set.
- Simultaneous allocate (accept) and retire (result or kill) of different ids: both applied, count net unchanged.
- busy_o = |busy.

## Timing
- Reset: state IDLE, busy = 0, count = 0, next_id = 0; all valid/pulse/sticky outputs 0, data outputs 0.
- Reset mid-operation discards all outstanding ids; later results for them flag protocol_err_o.
- issue_valid rises the cycle after offload handshake; commit_valid the cycle after issue handshake; offload_ready_o earliest the cycle after commit. Peak throughput 1 instruction / 3 cycles; on reject, 1 / 2 cycles.
- Result-to-writeback is combinational (0 cycles); no result buffering.
- accept_o/reject_o/offload_id_o are registered, asserted the cycle after issue handshake.

## Configuration
- CVXIF_INITIATOR_TIMEOUT_EN defined: counter increments each cycle busy_o = 1 with no result handshake; clears on result handshake or busy_o = 0; reaching TimeoutCycles sets timeout_o until reset.
- Not defined: no counter; timeout_o tied 0; TimeoutCycles unused.

## Test plan
- Offload instr 0x0000_000B, rs = {5, 7}, coprocessor accepts, then result id 0, data 12, rd 3, we 1 -> accept_o with id 0, one-cycle commit_valid kill 0, wb_valid_o with data 12, rd 3; busy_o back to 0.
- Coprocessor rejects -> reject_o pulse, no commit_valid, next offload reuses id 0.
- Four accepted offloads, no results -> offload_ready_o low; results return ids 2, 0, 3, 1 -> each forwarded once with correct data; ready restored after first result.
- offload_kill_i = 1, accepted -> commit_kill = 1, busy_o 0 the cycle after commit; later result id 0 -> protocol_err_o = 1, wb_valid_o stays 0.
- wb_ready_i low 5 cycles with result_valid high -> result_ready low, wb outputs stable; retire on first ready cycle.
- Macro on, TimeoutCycles = 16, accepted offload, no result -> timeout_o rises after 16 cycles and stays; macro off -> stays 0.

Source files
------------

// File: rtl/cvxif_offload_initiator.sv
// Core-side CV-X-IF initiator: combined issue/register handshake, one-cycle commit, out-of-order result forwarding.
// Optional watchdog enabled by defining CVXIF_INITIATOR_TIMEOUT_EN.
package cvxif_offload_pkg;
    localparam int unsigned CvxifNrRgprPorts = 2;
    localparam int unsigned CvxifXlen        = 32;
    localparam int unsigned CvxifIdWidth     = 3;
    localparam int unsigned CvxifHartidWidth = 2;

    typedef logic [CvxifHartidWidth-1:0] hartid_t;
    typedef logic [CvxifIdWidth-1:0]     id_t;

    typedef struct packed {
        logic [31:0] instr;
        hartid_t     hartid;
        id_t         id;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
    } x_issue_resp_t;

    typedef struct packed {
        hartid_t                                     hartid;
        id_t                                         id;
        logic [CvxifNrRgprPorts-1:0][CvxifXlen-1:0] rs;
        logic [CvxifNrRgprPorts-1:0]                 rs_valid;
    } x_register_t;

    typedef struct packed {
        hartid_t hartid;
        id_t     id;
        logic    commit_kill;
    } x_commit_t;

    typedef struct packed {
        id_t                  id;
        logic [CvxifXlen-1:0] data;
        logic [4:0]           rd;
        logic                 we;
    } x_result_t;

    typedef struct packed {
        logic         issue_valid;
        x_issue_req_t issue_req;
        logic         register_valid;
        x_register_t  register;
        logic         commit_valid;
        x_commit_t    commit;
        logic         result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic          issue_ready;
        x_issue_resp_t issue_resp;
        logic          result_valid;
        x_result_t     result;
    } cvxif_resp_t;
endpackage

// state  | meaning
// IDLE   | waiting for an offload from the issue stage
// ISSUE  | issue+register valid, held until coprocessor is ready
// COMMIT | single-cycle commit for the accepted instruction
module cvxif_offload_initiator
    import cvxif_offload_pkg::*;
#(
    parameter int unsigned NrRgprPorts    = CvxifNrRgprPorts,
    parameter int unsigned XLEN           = CvxifXlen,
    parameter int unsigned IdWidth        = CvxifIdWidth,
    parameter int unsigned MaxOutstanding = 4
`ifdef CVXIF_INITIATOR_TIMEOUT_EN
    ,
    parameter int unsigned TimeoutCycles  = 1024
`endif
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             offload_valid_i,
    output logic                             offload_ready_o,
    input  logic [31:0]                      offload_instr_i,
    input  logic [NrRgprPorts-1:0][XLEN-1:0] offload_rs_i,
    input  hartid_t                          offload_hartid_i,
    input  logic                             offload_kill_i,
    output logic                             accept_o,
    output logic                             reject_o,
    output logic [IdWidth-1:0]               offload_id_o,
    output cvxif_req_t                       cvxif_req_o,
    input  cvxif_resp_t                      cvxif_resp_i,
    output logic                             wb_valid_o,
    input  logic                             wb_ready_i,
    output logic [XLEN-1:0]                  wb_data_o,
    output logic [4:0]                       wb_rd_o,
    output logic                             wb_we_o,
    output logic [IdWidth-1:0]               wb_id_o,
    output logic                             busy_o,
    output logic                             protocol_err_o,
    output logic                             timeout_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_e;

    localparam int unsigned NumIds = 2 ** IdWidth;
    localparam int unsigned CntW   = $clog2(NumIds + 1);

    state_e                           state_q, state_d;
    logic [NumIds-1:0]                busy_q, busy_d, set_vec, clr_vec;
    logic [CntW-1:0]                  count;
    logic [IdWidth-1:0]               next_id_q, id_q;
    logic [31:0]                      instr_q;
    logic [NrRgprPorts-1:0][XLEN-1:0] rs_q;
    hartid_t                          hartid_q;
    logic                             kill_q, accept_q, reject_q, perr_q;
    logic                             offload_hs, issue_hs, accepted, rejected, kill_retire;
    logic                             res_known, result_ready, res_hs, wb_hs;

    assign count       = CntW'($countones(busy_q));
    assign busy_o      = |busy_q;
    assign offload_ready_o = (state_q == IDLE) && (count < CntW'(MaxOutstanding)) && !busy_q[next_id_q];
    assign offload_hs  = offload_valid_i && offload_ready_o;
    assign issue_hs    = (state_q == ISSUE) && cvxif_resp_i.issue_ready;
    assign accepted    = issue_hs && cvxif_resp_i.issue_resp.accept;
    assign rejected    = issue_hs && !cvxif_resp_i.issue_resp.accept;
    assign kill_retire = (state_q == COMMIT) && kill_q;

    // Results for ids we do not own are drained immediately so they cannot block the channel.
    assign res_known    = busy_q[cvxif_resp_i.result.id];
    assign result_ready = wb_ready_i || !res_known;
    assign res_hs       = cvxif_resp_i.result_valid && result_ready;
    assign wb_valid_o   = cvxif_resp_i.result_valid && res_known;
    assign wb_hs        = wb_valid_o && wb_ready_i;
    assign wb_data_o    = wb_valid_o ? cvxif_resp_i.result.data : '0;
    assign wb_rd_o      = wb_valid_o ? cvxif_resp_i.result.rd : '0;
    assign wb_we_o      = wb_valid_o && cvxif_resp_i.result.we;
    assign wb_id_o      = wb_valid_o ? cvxif_resp_i.result.id : '0;

    assign accept_o       = accept_q;
    assign reject_o       = reject_q;
    assign offload_id_o   = id_q;
    assign protocol_err_o = perr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (offload_hs) state_d = ISSUE;
            ISSUE:   if (issue_hs) state_d = cvxif_resp_i.issue_resp.accept ? COMMIT : IDLE;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (accepted)    set_vec[id_q] = 1'b1;
        if (wb_hs)       clr_vec[cvxif_resp_i.result.id] = 1'b1;
        if (kill_retire) clr_vec[id_q] = 1'b1;
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_comb begin
        cvxif_req_o                      = '0;
        cvxif_req_o.issue_valid          = (state_q == ISSUE);
        cvxif_req_o.issue_req.instr      = instr_q;
        cvxif_req_o.issue_req.hartid     = hartid_q;
        cvxif_req_o.issue_req.id         = id_q;
        cvxif_req_o.register_valid       = (state_q == ISSUE);
        cvxif_req_o.register.hartid      = hartid_q;
        cvxif_req_o.register.id          = id_q;
        cvxif_req_o.register.rs          = rs_q;
        cvxif_req_o.register.rs_valid    = '1;
        cvxif_req_o.commit_valid         = (state_q == COMMIT);
        cvxif_req_o.commit.hartid        = hartid_q;
        cvxif_req_o.commit.id            = id_q;
        cvxif_req_o.commit.commit_kill   = kill_q;
        cvxif_req_o.result_ready         = result_ready;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            busy_q    <= '0;
            next_id_q <= '0;
            id_q      <= '0;
            instr_q   <= '0;
            rs_q      <= '0;
            hartid_q  <= '0;
            kill_q    <= 1'b0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            accept_q <= accepted;
            reject_q <= rejected;
            if (offload_hs) begin
                instr_q  <= offload_instr_i;
                rs_q     <= offload_rs_i;
                hartid_q <= offload_hartid_i;
                kill_q   <= offload_kill_i;
                id_q     <= next_id_q;
            end
            if (accepted) next_id_q <= next_id_q + 1'b1;
            if (res_hs && !res_known) perr_q <= 1'b1;
        end
    end

`ifdef CVXIF_INITIATOR_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_cnt_q;
    logic            timeout_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else if (!busy_o || res_hs) begin
            tmo_cnt_q <= '0;
        end else if (tmo_cnt_q != TmoW'(TimeoutCycles)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TmoW'(TimeoutCycles - 1)) timeout_q <= 1'b1;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_cvxif_offload_initiator.sv
// Randomized self-checking bench for cvxif_offload_initiator against an id-occupancy reference model.
module tb_cvxif_offload_initiator;
    import cvxif_offload_pkg::*;

    localparam int MaxOut = 4;
    localparam int NumIds = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              offload_valid = 1'b0;
    logic              offload_ready_o;
    logic [31:0]       offload_instr = '0;
    logic [1:0][31:0]  offload_rs = '0;
    hartid_t           offload_hartid = '0;
    logic              offload_kill = 1'b0;
    logic              accept_o, reject_o;
    logic [2:0]        offload_id_o;
    cvxif_req_t        req;
    cvxif_resp_t       resp = '0;
    logic              wb_valid_o;
    logic              wb_ready = 1'b0;
    logic [31:0]       wb_data_o;
    logic [4:0]        wb_rd_o;
    logic              wb_we_o;
    logic [2:0]        wb_id_o;
    logic              busy_o, protocol_err_o, timeout_o;

    int vectors = 0;
    int miscompares = 0;

    bit outst[NumIds];
    int next_id_m;
    bit perr_m;

    always #5 clk_i = ~clk_i;

    cvxif_offload_initiator #(
        .MaxOutstanding(MaxOut)
`ifdef CVXIF_INITIATOR_TIMEOUT_EN
        , .TimeoutCycles(16)
`endif
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .offload_valid_i(offload_valid), .offload_ready_o(offload_ready_o),
        .offload_instr_i(offload_instr), .offload_rs_i(offload_rs),
        .offload_hartid_i(offload_hartid), .offload_kill_i(offload_kill),
        .accept_o(accept_o), .reject_o(reject_o), .offload_id_o(offload_id_o),
        .cvxif_req_o(req), .cvxif_resp_i(resp),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready), .wb_data_o(wb_data_o),
        .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_id_o(wb_id_o),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o), .timeout_o(timeout_o)
    );

    function automatic int count_m();
        int n = 0;
        for (int i = 0; i < NumIds; i++) n += int'(outst[i]);
        return n;
    endfunction

    function automatic logic any_m();
        return count_m() != 0;
    endfunction

    function automatic logic ready_m();
        return (count_m() < MaxOut) && !outst[next_id_m];
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        offload_valid = 1'b0;
        resp = '0;
        wb_ready = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < NumIds; i++) outst[i] = 1'b0;
        next_id_m = 0;
        perr_m = 1'b0;
    endtask

    task automatic do_offload(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1,
                              input hartid_t hart, input bit kill, input bit acc, input int stall,
                              input bit res_en, input int res_id, input logic [31:0] res_data,
                              output int id_used);
        id_t  id_exp;
        logic ok;
        id_used = next_id_m;
        id_exp  = id_t'(next_id_m);
        vectors++;
        if (offload_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL offload_ready before offload: got %b want 1", offload_ready_o);
            id_used = -1;
            return;
        end
        offload_instr  = instr;
        offload_rs     = {rs1, rs0};
        offload_hartid = hart;
        offload_kill   = kill;
        offload_valid  = 1'b1;
        @(posedge clk_i); #1;
        offload_valid  = 1'b0;
        offload_instr  = $urandom;
        offload_rs     = {$urandom, $urandom};
        offload_hartid = hartid_t'($urandom_range(0, 3));
        offload_kill   = ~kill;
        for (int s = 0; s <= stall; s++) begin
            ok = req.issue_valid === 1'b1 && req.register_valid === 1'b1 &&
                 req.issue_req.instr === instr && req.issue_req.id === id_exp &&
                 req.register.id === id_exp && req.issue_req.hartid === hart &&
                 req.register.hartid === hart && req.register.rs[0] === rs0 &&
                 req.register.rs[1] === rs1 && req.register.rs_valid === 2'b11 &&
                 req.commit_valid === 1'b0 && offload_ready_o === 1'b0;
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL issue_channel cyc %0d: valid %b%b instr %h id %0d rs %h %h hart %0d; want instr %h id %0d rs %h %h hart %0d",
                         s, req.issue_valid, req.register_valid, req.issue_req.instr, req.issue_req.id,
                         req.register.rs[0], req.register.rs[1], req.issue_req.hartid, instr, id_exp, rs0, rs1, hart);
            end
            if (s < stall) begin
                @(posedge clk_i); #1;
            end
        end
        resp.issue_ready       = 1'b1;
        resp.issue_resp.accept = acc;
        if (res_en) begin
            resp.result_valid = 1'b1;
            resp.result.id    = id_t'(res_id);
            resp.result.data  = res_data;
            resp.result.rd    = 5'($urandom);
            resp.result.we    = 1'b1;
            wb_ready          = 1'b1;
            #1;
            vectors++;
            if (wb_valid_o !== 1'b1 || wb_data_o !== res_data || wb_id_o !== id_t'(res_id)) begin
                miscompares++;
                $display("FAIL concurrent_wb: valid %b data %h id %0d want 1 %h %0d", wb_valid_o, wb_data_o, wb_id_o, res_data, res_id);
            end
        end
        @(posedge clk_i); #1;
        resp.issue_ready       = 1'b0;
        resp.issue_resp.accept = 1'b0;
        resp.result_valid      = 1'b0;
        wb_ready               = 1'b0;
        if (res_en) outst[res_id] = 1'b0;
        if (acc) begin
            outst[id_used] = 1'b1;
            next_id_m = (next_id_m + 1) % NumIds;
        end
        #1;
        vectors++;
        if (accept_o !== acc || reject_o !== !acc || offload_id_o !== id_exp) begin
            miscompares++;
            $display("FAIL outcome_pulse: accept %b reject %b id %0d want %b %b %0d", accept_o, reject_o, offload_id_o, acc, !acc, id_exp);
        end
        vectors++;
        if (req.commit_valid !== acc || (acc && (req.commit.id !== id_exp || req.commit.hartid !== hart || req.commit.commit_kill !== kill))) begin
            miscompares++;
            $display("FAIL commit: valid %b id %0d hart %0d kill %b want %b %0d %0d %b", req.commit_valid, req.commit.id,
                     req.commit.hartid, req.commit.commit_kill, acc, id_exp, hart, kill);
        end
        vectors++;
        if (busy_o !== any_m()) begin
            miscompares++;
            $display("FAIL busy_at_outcome: got %b want %b", busy_o, any_m());
        end
        if (acc) begin
            if (kill) outst[id_used] = 1'b0;
            @(posedge clk_i); #1;
            vectors++;
            if (req.commit_valid !== 1'b0 || accept_o !== 1'b0 || busy_o !== any_m() || offload_ready_o !== ready_m()) begin
                miscompares++;
                $display("FAIL after_commit: commit %b accept %b busy %b ready %b want 0 0 %b %b", req.commit_valid, accept_o,
                         busy_o, offload_ready_o, any_m(), ready_m());
            end
        end else begin
            vectors++;
            if (offload_ready_o !== ready_m()) begin
                miscompares++;
                $display("FAIL ready_after_reject: got %b want %b", offload_ready_o, ready_m());
            end
        end
    endtask

    task automatic send_result(input int id, input logic [31:0] data, input logic [4:0] rd, input bit we, input int hold);
        bit known;
        known = outst[id];
        resp.result_valid = 1'b1;
        resp.result.id    = id_t'(id);
        resp.result.data  = data;
        resp.result.rd    = rd;
        resp.result.we    = we;
        wb_ready          = 1'b0;
        for (int s = 0; s <= hold; s++) begin
            #1;
            vectors++;
            if (wb_valid_o !== known || req.result_ready !== !known || wb_data_o !== (known ? data : 32'h0) ||
                wb_rd_o !== (known ? rd : 5'h0) || wb_we_o !== (known & we) || wb_id_o !== (known ? id_t'(id) : 3'h0)) begin
                miscompares++;
                $display("FAIL wb_stall cyc %0d: valid %b rdy %b data %h rd %0d we %b id %0d want %b %b %h %0d %b %0d", s,
                         wb_valid_o, req.result_ready, wb_data_o, wb_rd_o, wb_we_o, wb_id_o, known, !known, data, rd, we, id);
            end
            if (s < hold) @(posedge clk_i);
        end
        wb_ready = 1'b1;
        #1;
        vectors++;
        if (wb_valid_o !== known || req.result_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wb_ready_cycle: valid %b rdy %b want %b 1", wb_valid_o, req.result_ready, known);
        end
        @(posedge clk_i); #1;
        resp.result_valid = 1'b0;
        wb_ready          = 1'b0;
        if (known) outst[id] = 1'b0;
        else perr_m = 1'b1;
        #1;
        vectors++;
        if (protocol_err_o !== perr_m || busy_o !== any_m() || offload_ready_o !== ready_m() || wb_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL after_result: perr %b busy %b ready %b wbv %b want %b %b %b 0", protocol_err_o, busy_o,
                     offload_ready_o, wb_valid_o, perr_m, any_m(), ready_m());
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (offload_ready_o !== 1'b1 || busy_o !== 1'b0 || accept_o !== 1'b0 || reject_o !== 1'b0 || offload_id_o !== 3'd0 ||
            wb_valid_o !== 1'b0 || wb_data_o !== 32'h0 || protocol_err_o !== 1'b0 || timeout_o !== 1'b0 ||
            req.issue_valid !== 1'b0 || req.register_valid !== 1'b0 || req.commit_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready %b busy %b acc %b rej %b id %0d wbv %b perr %b tmo %b iv %b cv %b",
                     offload_ready_o, busy_o, accept_o, reject_o, offload_id_o, wb_valid_o, protocol_err_o, timeout_o,
                     req.issue_valid, req.commit_valid);
        end
    endtask

    task automatic test_basic();
        int id;
        do_offload(32'h0000_000B, 32'd5, 32'd7, 2'd0, 1'b0, 1'b1, 1, 1'b0, 0, 32'h0, id);
        send_result(0, 32'd12, 5'd3, 1'b1, 0);
    endtask

    task automatic test_reject();
        int id;
        do_reset();
        do_offload($urandom, $urandom, $urandom, 2'd1, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, id);
        do_offload($urandom, $urandom, $urandom, 2'd2, 1'b0, 1'b1, 2, 1'b0, 0, 32'h0, id);
        send_result(0, $urandom, 5'd9, 1'b1, 0);
    endtask

    task automatic test_full();
        int ids[4];
        logic [31:0] d[4];
        int order[4] = '{2, 0, 3, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_offload($urandom, $urandom, $urandom, hartid_t'($urandom_range(0, 3)), 1'b0, 1'b1, $urandom_range(0, 2),
                       1'b0, 0, 32'h0, ids[i]);
            d[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) send_result(ids[order[i]], d[order[i]], 5'($urandom), 1'($urandom), $urandom_range(0, 1));
    endtask

    task automatic test_stall();
        int id;
        do_offload($urandom, $urandom, $urandom, 2'd3, 1'b0, 1'b1, 0, 1'b0, 0, 32'h0, id);
        send_result(id, 32'hDEAD_BEEF, 5'd17, 1'b1, 5);
    endtask

    task automatic test_kill();
        int id;
        do_reset();
        do_offload($urandom, $urandom, $urandom, 2'd0, 1'b1, 1'b1, 0, 1'b0, 0, 32'h0, id);
        send_result(id, 32'd44, 5'd1, 1'b1, 0);
    endtask

    task automatic test_random();
        int id, pick, q[$];
        do_reset();
        for (int it = 0; it < 250; it++) begin
            q.delete();
            for (int i = 0; i < NumIds; i++) if (outst[i]) q.push_back(i);
            if (ready_m() && $urandom_range(0, 99) < 55) begin
                bit res_en = (q.size() != 0) && ($urandom_range(0, 99) < 40);
                pick = res_en ? q[$urandom_range(0, q.size() - 1)] : 0;
                do_offload($urandom, $urandom, $urandom, hartid_t'($urandom_range(0, 3)), $urandom_range(0, 99) < 15,
                           $urandom_range(0, 99) < 75, $urandom_range(0, 2), res_en, pick, $urandom, id);
            end else if (q.size() != 0 && $urandom_range(0, 99) < 92) begin
                send_result(q[$urandom_range(0, q.size() - 1)], $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3));
            end else begin
                pick = $urandom_range(0, NumIds - 1);
                if (!outst[pick]) send_result(pick, $urandom, 5'($urandom), 1'b1, 0);
            end
        end
    endtask

    task automatic test_timeout();
        int id, first;
        do_reset();
        do_offload($urandom, $urandom, $urandom, 2'd0, 1'b0, 1'b1, 0, 1'b0, 0, 32'h0, id);
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_i); #1;
            if (first < 0 && timeout_o === 1'b1) first = n;
        end
`ifdef CVXIF_INITIATOR_TIMEOUT_EN
        vectors++;
        if (first != 15 || timeout_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_rise: first seen cycle %0d level %b want 15 1", first, timeout_o);
        end
`else
        vectors++;
        if (first != -1) begin
            miscompares++;
            $display("FAIL timeout_disabled: rose at cycle %0d want never", first);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int id;
        do_offload($urandom, $urandom, $urandom, 2'd1, 1'b0, 1'b1, 0, 1'b0, 0, 32'h0, id);
        do_reset();
        #1;
        vectors++;
        if (busy_o !== 1'b0 || timeout_o !== 1'b0 || protocol_err_o !== 1'b0 || offload_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: busy %b tmo %b perr %b ready %b want 0 0 0 1", busy_o, timeout_o, protocol_err_o, offload_ready_o);
        end
        send_result(id, $urandom, 5'd2, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_full();
        test_stall();
        test_kill();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
